// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the MEM stage and data memory
// Signals:
//   mem_req    request, held until ack or abort (stage -> memory)
//   mem_we     1 = write (stage -> memory)
//   mem_addr   word-aligned address (stage -> memory)
//   mem_wdata  lane-replicated store data (stage -> memory)
//   mem_be     byte enables (stage -> memory)
//   mem_ack    completion strobe (memory -> stage)
//   mem_rdata  read word, valid with mem_ack (memory -> stage)
interface mem_access_stage_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: EX_MEM load/store to req/ack memory access, MEM_WB registers
// Ports:
//   clk, Rst              clock, synchronous active-high reset
//   dbg                   debug freeze (honoured in IDLE only)
//   EX_MEM_*              execute-stage results and load/store control
//   bus                   data-memory req/ack bus (master side)
//   mem_hold              combinational stall request to IF/ID/EX
//   MEM_WB_rd/regwrite    registered writeback destination / enable
//   WB_res                registered writeback value
//   misalign_err          one-cycle pulse: misaligned access dropped
//   bus_err               one-cycle pulse: access aborted on timeout
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic        EX_MEM_regwrite,
  input  logic [4:0]  EX_MEM_rd,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_dout_rs2,
  input  logic [2:0]  EX_MEM_storecntrl,
  input  logic [4:0]  EX_MEM_loadcntrl,
  mem_access_stage_if.master bus,
  output logic        mem_hold,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_regwrite,
  output logic [31:0] WB_res,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, next_state;

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [CW-1:0]     tcnt;

  // Request context kept for the writeback when the ack arrives
  logic [4:0] lat_rd;
  logic       lat_rw;
  logic [1:0] lat_a;
  logic       lat_lb, lat_lh, lat_lbu, lat_lhu;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

  // Decode of the op waiting in EX_MEM
  logic        memop, is_store;
  logic        sz_byte, sz_half, sz_word;
  logic        aligned, access, misalign;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] addr_word;

  always_comb begin
    memop    = EX_MEM_memread | EX_MEM_memwrite;
    // A store wins when both read and write are flagged
    is_store = EX_MEM_memwrite;
    if (is_store) begin
      sz_byte = EX_MEM_storecntrl[0];
      sz_half = EX_MEM_storecntrl[1] & ~EX_MEM_storecntrl[0];
    end else begin
      sz_byte = EX_MEM_loadcntrl[0] | EX_MEM_loadcntrl[3];
      sz_half = (EX_MEM_loadcntrl[1] | EX_MEM_loadcntrl[4]) & ~sz_byte;
    end
    // Word access when explicitly selected or when no narrower size is given
    sz_word = (is_store ? EX_MEM_storecntrl[2] : EX_MEM_loadcntrl[2]) | (~sz_byte & ~sz_half);

    aligned  = sz_byte
             | (sz_half & ~EX_MEM_alures[0])
             | (sz_word & ~sz_half & (EX_MEM_alures[1:0] == 2'b00));
    access   = memop & aligned;
    misalign = memop & ~aligned;

    addr_word = {EX_MEM_alures[31:2], 2'b00};

    st_wdata = EX_MEM_dout_rs2;
    st_be    = 4'b1111;
    if (is_store && sz_byte) begin
      st_wdata = {4{EX_MEM_dout_rs2[7:0]}};
      st_be    = 4'b0001 << EX_MEM_alures[1:0];
    end else if (is_store && sz_half) begin
      st_wdata = {2{EX_MEM_dout_rs2[15:0]}};
      st_be    = 4'b0011 << {EX_MEM_alures[1], 1'b0};
    end
  end

  // Load data extraction from the returned word
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = bus.mem_rdata[{lat_a, 3'b000} +: 8];
    ld_half = lat_a[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    if (lat_lb)       ld_ext = {{24{ld_byte[7]}}, ld_byte};
    else if (lat_lbu) ld_ext = {24'd0, ld_byte};
    else if (lat_lh)  ld_ext = {{16{ld_half[15]}}, ld_half};
    else if (lat_lhu) ld_ext = {16'd0, ld_half};
    else              ld_ext = bus.mem_rdata;
  end

  logic timeout_hit;
  logic start, complete, abort;

  assign timeout_hit = (tcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_hold   = 1'b0;
    start      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!dbg && access) begin
          mem_hold   = 1'b1;
          start      = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // Hold drops in the ack or abort cycle so EX advances on the same edge
        if (bus.mem_ack) begin
          complete   = 1'b1;
          next_state = S_IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          next_state = S_IDLE;
        end else begin
          mem_hold = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      tcnt            <= '0;
      lat_rd          <= '0;
      lat_rw          <= 1'b0;
      lat_a           <= '0;
      lat_lb          <= 1'b0;
      lat_lh          <= 1'b0;
      lat_lbu         <= 1'b0;
      lat_lhu         <= 1'b0;
      MEM_WB_rd       <= '0;
      MEM_WB_regwrite <= 1'b0;
      WB_res          <= '0;
      misalign_err    <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;

      if (start) begin
        req_q           <= 1'b1;
        we_q            <= is_store;
        addr_q          <= addr_word[ADDR_W-1:0];
        wdata_q         <= st_wdata;
        be_q            <= st_be;
        tcnt            <= '0;
        lat_rd          <= EX_MEM_rd;
        lat_rw          <= EX_MEM_regwrite;
        lat_a           <= EX_MEM_alures[1:0];
        lat_lb          <= EX_MEM_loadcntrl[0];
        lat_lh          <= EX_MEM_loadcntrl[1];
        lat_lbu         <= EX_MEM_loadcntrl[3];
        lat_lhu         <= EX_MEM_loadcntrl[4];
        // Bubble into WB while the access is outstanding
        MEM_WB_regwrite <= 1'b0;
      end else if (state == S_IDLE && !dbg) begin
        if (misalign) begin
          misalign_err    <= 1'b1;
          MEM_WB_regwrite <= 1'b0;
        end else begin
          MEM_WB_rd       <= EX_MEM_rd;
          MEM_WB_regwrite <= EX_MEM_regwrite;
          WB_res          <= EX_MEM_alures;
        end
      end

      if (complete) begin
        req_q           <= 1'b0;
        MEM_WB_rd       <= lat_rd;
        MEM_WB_regwrite <= lat_rw & ~we_q;
        if (!we_q) WB_res <= ld_ext;
      end

      if (abort) begin
        req_q           <= 1'b0;
        bus_err         <= 1'b1;
        MEM_WB_regwrite <= 1'b0;
      end

      if (state == S_WAIT && !bus.mem_ack && !timeout_hit) tcnt <= tcnt + 1'b1;
    end
  end

endmodule
